// File: rtl/decode_issue_stage.sv
// Decode-and-issue stage feeding the 16-bit ALU: valid/ready intake, one output
// pipeline register, architectural carry/borrow flags, and HALT / soft-RESET sequencing.
module decode_issue_stage (
  input  logic        clk_pi,
  input  logic        reset_pi,
  input  logic [15:0] instr_pi,
  input  logic        instr_valid_pi,
  output logic        instr_ready_po,
  input  logic        ex_ready_pi,
  output logic        ex_valid_po,
  output logic        arith_1op_po,
  output logic        arith_2op_po,
  output logic        addi_po,
  output logic        subi_po,
  output logic        load_or_store_po,
  output logic [2:0]  alu_func_po,
  output logic [5:0]  immediate_po,
  output logic [2:0]  rd_addr_po,
  output logic [2:0]  rs1_addr_po,
  output logic [2:0]  rs2_addr_po,
  output logic        reg_write_po,
  output logic        mem_read_po,
  output logic        mem_write_po,
  output logic [1:0]  branch_po,
  output logic        branch_carry_po,
  output logic        jump_po,
  output logic [11:0] jump_target_po,
  output logic        stc_cmd_po,
  output logic        stb_cmd_po,
  input  logic        flag_we_pi,
  input  logic        alu_carry_pi,
  input  logic        alu_borrow_pi,
  output logic        carry_flag_po,
  output logic        borrow_flag_po,
  output logic        soft_reset_po,
  output logic        halted_po
);

  typedef enum logic {
    RUN,
    HALTED
  } state_e;

  state_e state_q;

  logic [3:0]  opcode;
  logic [11:0] ctrl_code;
  logic        is_reset_cmd;
  logic        is_halt_cmd;
  logic        accept;

  logic        ex_valid_q;
  logic        arith_1op_d, arith_1op_q;
  logic        arith_2op_d, arith_2op_q;
  logic        addi_d, addi_q;
  logic        subi_d, subi_q;
  logic        ls_d, ls_q;
  logic [2:0]  func_d, func_q;
  logic [5:0]  imm_d, imm_q;
  logic [2:0]  rd_d, rd_q;
  logic [2:0]  rs1_d, rs1_q;
  logic [2:0]  rs2_d, rs2_q;
  logic        reg_write_d, reg_write_q;
  logic        mem_read_d, mem_read_q;
  logic        mem_write_d, mem_write_q;
  logic [1:0]  branch_d, branch_q;
  logic        bc_d, bc_q;
  logic        jump_d, jump_q;
  logic [11:0] jt_d, jt_q;
  logic        stc_d, stc_q;
  logic        stb_d, stb_q;
  logic        carry_q, borrow_q;
  logic        soft_reset_q;

  assign opcode       = instr_pi[15:12];
  assign ctrl_code    = instr_pi[11:0];
  assign is_reset_cmd = (opcode == 4'hF) && (ctrl_code == 12'hAAA);
  assign is_halt_cmd  = (opcode == 4'hF) && (ctrl_code == 12'hFFF);

  assign instr_ready_po = (state_q == RUN) && (!ex_valid_q || ex_ready_pi);
  assign accept         = instr_valid_pi && instr_ready_po;

  // Register addresses are raw instruction slices; every other control is opcode-qualified.
  always_comb begin
    arith_1op_d = 1'b0;
    arith_2op_d = 1'b0;
    addi_d      = 1'b0;
    subi_d      = 1'b0;
    ls_d        = 1'b0;
    func_d      = '0;
    imm_d       = '0;
    rd_d        = instr_pi[11:9];
    rs1_d       = instr_pi[8:6];
    rs2_d       = instr_pi[5:3];
    reg_write_d = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    branch_d    = 2'b00;
    bc_d        = 1'b0;
    jump_d      = 1'b0;
    jt_d        = '0;
    stc_d       = 1'b0;
    stb_d       = 1'b0;
    case (opcode)
      4'h1: begin
        arith_2op_d = 1'b1;
        func_d      = instr_pi[2:0];
        reg_write_d = 1'b1;
      end
      4'h2: begin
        arith_1op_d = 1'b1;
        func_d      = instr_pi[2:0];
        reg_write_d = 1'b1;
      end
      4'h3: begin
        imm_d       = instr_pi[5:0];
        reg_write_d = 1'b1;
      end
      4'h4: begin
        addi_d      = 1'b1;
        imm_d       = instr_pi[5:0];
        reg_write_d = 1'b1;
      end
      4'h5: begin
        subi_d      = 1'b1;
        imm_d       = instr_pi[5:0];
        reg_write_d = 1'b1;
      end
      4'h6: begin
        ls_d        = 1'b1;
        imm_d       = instr_pi[5:0];
        reg_write_d = 1'b1;
        mem_read_d  = 1'b1;
      end
      4'h7: begin
        ls_d        = 1'b1;
        imm_d       = instr_pi[5:0];
        mem_write_d = 1'b1;
      end
      4'h8: begin
        branch_d = 2'b01;
        imm_d    = instr_pi[5:0];
      end
      4'h9: begin
        branch_d = 2'b10;
        imm_d    = instr_pi[5:0];
      end
      4'hA: begin
        branch_d = 2'b11;
        imm_d    = instr_pi[5:0];
      end
      4'hB: begin
        bc_d  = 1'b1;
        imm_d = instr_pi[5:0];
      end
      4'hC: begin
        jump_d = 1'b1;
        jt_d   = instr_pi[11:0];
      end
      4'hF: begin
        stc_d = (ctrl_code == 12'h001);
        stb_d = (ctrl_code == 12'h002);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_pi) begin
    if (reset_pi) begin
      state_q      <= RUN;
      ex_valid_q   <= 1'b0;
      arith_1op_q  <= 1'b0;
      arith_2op_q  <= 1'b0;
      addi_q       <= 1'b0;
      subi_q       <= 1'b0;
      ls_q         <= 1'b0;
      func_q       <= '0;
      imm_q        <= '0;
      rd_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      branch_q     <= '0;
      bc_q         <= 1'b0;
      jump_q       <= 1'b0;
      jt_q         <= '0;
      stc_q        <= 1'b0;
      stb_q        <= 1'b0;
      carry_q      <= 1'b0;
      borrow_q     <= 1'b0;
      soft_reset_q <= 1'b0;
    end else begin
      soft_reset_q <= accept && is_reset_cmd;

      // A software RESET accepted this cycle overrides any flag commit.
      if (accept && is_reset_cmd) begin
        carry_q  <= 1'b0;
        borrow_q <= 1'b0;
      end else if (flag_we_pi) begin
        carry_q  <= alu_carry_pi;
        borrow_q <= alu_borrow_pi;
      end

      if (accept && !is_reset_cmd) begin
        ex_valid_q  <= 1'b1;
        arith_1op_q <= arith_1op_d;
        arith_2op_q <= arith_2op_d;
        addi_q      <= addi_d;
        subi_q      <= subi_d;
        ls_q        <= ls_d;
        func_q      <= func_d;
        imm_q       <= imm_d;
        rd_q        <= rd_d;
        rs1_q       <= rs1_d;
        rs2_q       <= rs2_d;
        reg_write_q <= reg_write_d;
        mem_read_q  <= mem_read_d;
        mem_write_q <= mem_write_d;
        branch_q    <= branch_d;
        bc_q        <= bc_d;
        jump_q      <= jump_d;
        jt_q        <= jt_d;
        stc_q       <= stc_d;
        stb_q       <= stb_d;
        if (is_halt_cmd) begin
          state_q <= HALTED;
        end
      end else if (accept || ex_ready_pi) begin
        ex_valid_q <= 1'b0;
      end
    end
  end

  assign ex_valid_po      = ex_valid_q;
  assign arith_1op_po     = arith_1op_q;
  assign arith_2op_po     = arith_2op_q;
  assign addi_po          = addi_q;
  assign subi_po          = subi_q;
  assign load_or_store_po = ls_q;
  assign alu_func_po      = func_q;
  assign immediate_po     = imm_q;
  assign rd_addr_po       = rd_q;
  assign rs1_addr_po      = rs1_q;
  assign rs2_addr_po      = rs2_q;
  assign reg_write_po     = reg_write_q;
  assign mem_read_po      = mem_read_q;
  assign mem_write_po     = mem_write_q;
  assign branch_po        = branch_q;
  assign branch_carry_po  = bc_q;
  assign jump_po          = jump_q;
  assign jump_target_po   = jt_q;
  assign stc_cmd_po       = stc_q;
  assign stb_cmd_po       = stb_q;
  assign carry_flag_po    = carry_q;
  assign borrow_flag_po   = borrow_q;
  assign soft_reset_po    = soft_reset_q;
  assign halted_po        = (state_q == HALTED);

endmodule

// File: tb/tb_decode_issue_stage.sv
// Bench for decode_issue_stage: decode table, hand-written handshake/HALT/RESET
// sequences, and randomized traffic against an opcode-rule reference model.
module tb_decode_issue_stage;

  typedef struct packed {
    logic        a1, a2, addi, subi, ls;
    logic [2:0]  func;
    logic [5:0]  imm;
    logic [2:0]  rd, rs1, rs2;
    logic        rw, mr, mw;
    logic [1:0]  br;
    logic        bc, j;
    logic [11:0] jt;
    logic        stc, stb;
  } dec_t;

  typedef struct {
    logic [15:0] instr;
    dec_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_pi = 1'b1;
  logic [15:0] instr_pi = '0;
  logic        instr_valid_pi = 1'b0;
  logic        instr_ready_po;
  logic        ex_ready_pi = 1'b0;
  logic        ex_valid_po;
  logic        arith_1op_po, arith_2op_po, addi_po, subi_po, load_or_store_po;
  logic [2:0]  alu_func_po;
  logic [5:0]  immediate_po;
  logic [2:0]  rd_addr_po, rs1_addr_po, rs2_addr_po;
  logic        reg_write_po, mem_read_po, mem_write_po;
  logic [1:0]  branch_po;
  logic        branch_carry_po, jump_po;
  logic [11:0] jump_target_po;
  logic        stc_cmd_po, stb_cmd_po;
  logic        flag_we_pi = 1'b0, alu_carry_pi = 1'b0, alu_borrow_pi = 1'b0;
  logic        carry_flag_po, borrow_flag_po, soft_reset_po, halted_po;

  dec_t dut_f;
  assign dut_f = {arith_1op_po, arith_2op_po, addi_po, subi_po, load_or_store_po,
                  alu_func_po, immediate_po, rd_addr_po, rs1_addr_po, rs2_addr_po,
                  reg_write_po, mem_read_po, mem_write_po, branch_po,
                  branch_carry_po, jump_po, jump_target_po, stc_cmd_po, stb_cmd_po};

  decode_issue_stage dut (
    .clk_pi(clk), .reset_pi(reset_pi), .instr_pi(instr_pi),
    .instr_valid_pi(instr_valid_pi), .instr_ready_po(instr_ready_po),
    .ex_ready_pi(ex_ready_pi), .ex_valid_po(ex_valid_po),
    .arith_1op_po(arith_1op_po), .arith_2op_po(arith_2op_po), .addi_po(addi_po),
    .subi_po(subi_po), .load_or_store_po(load_or_store_po), .alu_func_po(alu_func_po),
    .immediate_po(immediate_po), .rd_addr_po(rd_addr_po), .rs1_addr_po(rs1_addr_po),
    .rs2_addr_po(rs2_addr_po), .reg_write_po(reg_write_po), .mem_read_po(mem_read_po),
    .mem_write_po(mem_write_po), .branch_po(branch_po), .branch_carry_po(branch_carry_po),
    .jump_po(jump_po), .jump_target_po(jump_target_po), .stc_cmd_po(stc_cmd_po),
    .stb_cmd_po(stb_cmd_po), .flag_we_pi(flag_we_pi), .alu_carry_pi(alu_carry_pi),
    .alu_borrow_pi(alu_borrow_pi), .carry_flag_po(carry_flag_po),
    .borrow_flag_po(borrow_flag_po), .soft_reset_po(soft_reset_po), .halted_po(halted_po)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;

  // Reference model state
  logic m_valid = 1'b0, m_halted = 1'b0, m_carry = 1'b0, m_borrow = 1'b0, m_soft = 1'b0;
  dec_t m_out = '0;

  function automatic dec_t model_decode(input logic [15:0] ins);
    dec_t d;
    int   op;
    d     = '0;
    op    = int'(ins[15:12]);
    d.rd  = ins[11:9];
    d.rs1 = ins[8:6];
    d.rs2 = ins[5:3];
    d.a2   = (op == 1);
    d.a1   = (op == 2);
    d.addi = (op == 4);
    d.subi = (op == 5);
    d.ls   = (op == 6) || (op == 7);
    if (op == 1 || op == 2) d.func = ins[2:0];
    if (op >= 3 && op <= 11) d.imm = ins[5:0];
    d.rw = (op >= 1 && op <= 6);
    d.mr = (op == 6);
    d.mw = (op == 7);
    if (op >= 8 && op <= 10) d.br = 2'(op - 7);
    d.bc = (op == 11);
    d.j  = (op == 12);
    if (d.j) d.jt = ins[11:0];
    d.stc = (ins == 16'hF001);
    d.stb = (ins == 16'hF002);
    return d;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, check ready, advance model at posedge, check outputs at next negedge.
  task automatic cycle(input logic rst, input logic v, input logic [15:0] ins,
                       input logic exr, input logic fwe, input logic c, input logic b);
    logic rdy, acc;
    reset_pi = rst; instr_valid_pi = v; instr_pi = ins;
    ex_ready_pi = exr; flag_we_pi = fwe; alu_carry_pi = c; alu_borrow_pi = b;
    #1;
    rdy = !m_halted && (!m_valid || exr);
    chk("instr_ready", 64'(instr_ready_po), 64'(rdy));
    @(posedge clk);
    acc = v && rdy;
    if (rst) begin
      m_valid = 0; m_halted = 0; m_carry = 0; m_borrow = 0; m_soft = 0; m_out = '0;
    end else begin
      m_soft = acc && (ins == 16'hFAAA);
      if (m_soft) begin
        m_carry = 0; m_borrow = 0;
      end else if (fwe) begin
        m_carry = c; m_borrow = b;
      end
      if (acc && ins != 16'hFAAA) begin
        m_valid = 1;
        m_out   = model_decode(ins);
        if (ins == 16'hFFFF) m_halted = 1;
      end else if (acc || exr) begin
        m_valid = 0;
      end
    end
    @(negedge clk);
    chk("ex_valid", 64'(ex_valid_po), 64'(m_valid));
    chk("fields", 64'(dut_f), 64'(m_out));
    chk("flags", 64'({carry_flag_po, borrow_flag_po}), 64'({m_carry, m_borrow}));
    chk("soft_reset", 64'(soft_reset_po), 64'(m_soft));
    chk("halted", 64'(halted_po), 64'(m_halted));
  endtask

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{16'h1298, '{a2:1, rd:1, rs1:2, rs2:3, rw:1, default:0}};
    tbl[1]  = '{16'h2A3D, '{a1:1, func:5, rd:5, rs1:0, rs2:7, rw:1, default:0}};
    tbl[2]  = '{16'h3ABC, '{imm:60, rd:5, rs1:2, rs2:7, rw:1, default:0}};
    tbl[3]  = '{16'h4285, '{addi:1, imm:5, rd:1, rs1:2, rw:1, default:0}};
    tbl[4]  = '{16'h5285, '{subi:1, imm:5, rd:1, rs1:2, rw:1, default:0}};
    tbl[5]  = '{16'h6FC1, '{ls:1, imm:1, rd:7, rs1:7, rw:1, mr:1, default:0}};
    tbl[6]  = '{16'h7E3F, '{ls:1, imm:63, rd:7, rs2:7, mw:1, default:0}};
    tbl[7]  = '{16'h8285, '{br:1, imm:5, rd:1, rs1:2, default:0}};
    tbl[8]  = '{16'h9000, '{br:2, default:0}};
    tbl[9]  = '{16'hA001, '{br:3, imm:1, default:0}};
    tbl[10] = '{16'hB02A, '{bc:1, imm:42, rs2:5, default:0}};
    tbl[11] = '{16'hC07B, '{j:1, jt:12'h07B, rs1:1, rs2:7, default:0}};
    tbl[12] = '{16'hF001, '{stc:1, default:0}};
    tbl[13] = '{16'hF002, '{stb:1, default:0}};
    tbl[14] = '{16'hF123, '{rs1:4, rs2:4, default:0}};
    tbl[15] = '{16'hD123, '{rs1:4, rs2:4, default:0}};

    @(negedge clk);
    cycle(1, 0, 16'h0, 0, 0, 0, 0);
    cycle(1, 1, 16'h1298, 1, 1, 1, 1);
    chk("reset_fields", 64'(dut_f), 64'(0));
    chk("reset_valid", 64'(ex_valid_po), 64'(0));
    chk("reset_flags", 64'({carry_flag_po, borrow_flag_po, soft_reset_po, halted_po}), 64'(0));

    // Decode table, back-to-back at full throughput
    for (int i = 0; i < 16; i++) begin
      cycle(0, 1, tbl[i].instr, 1, 0, 0, 0);
      chk($sformatf("tbl_%h", tbl[i].instr), 64'(dut_f), 64'(tbl[i].exp));
      chk($sformatf("tbl_valid_%h", tbl[i].instr), 64'(ex_valid_po), 64'(1));
    end
    cycle(0, 0, 16'h0, 1, 0, 0, 0);

    // ADDI then stall with SUBI offered
    cycle(0, 1, 16'h4285, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cycle(0, 1, 16'h5285, 0, 0, 0, 0);
      chk("stall_hold", 64'({addi_po, immediate_po, ex_valid_po}), 64'({1'b1, 6'd5, 1'b1}));
      chk("stall_ready", 64'(instr_ready_po), 64'(0));
    end
    cycle(0, 1, 16'h5285, 1, 0, 0, 0);
    chk("release_subi", 64'({subi_po, addi_po, immediate_po}), 64'({1'b1, 1'b0, 6'd5}));

    // Flag commit, then software RESET overriding a simultaneous commit
    cycle(0, 0, 16'h0, 1, 1, 1, 0);
    chk("flag_commit", 64'({carry_flag_po, borrow_flag_po}), 64'(2'b10));
    cycle(0, 1, 16'hFAAA, 1, 1, 1, 1);
    chk("sreset_pulse", 64'({soft_reset_po, carry_flag_po, borrow_flag_po, ex_valid_po}), 64'(4'b1000));
    cycle(0, 0, 16'h0, 1, 0, 0, 0);
    chk("sreset_end", 64'({soft_reset_po, halted_po}), 64'(0));

    // HALT, then blocked intake until reset_pi
    cycle(0, 1, 16'hFFFF, 1, 0, 0, 0);
    chk("halt_nop", 64'({dut_f.rw, dut_f.stc, dut_f.stb, dut_f.j, dut_f.br, ex_valid_po, halted_po}), 64'(8'b00000011));
    for (int k = 0; k < 4; k++) begin
      cycle(0, 1, 16'h1298, (k != 0), 0, 0, 0);
      chk("halt_ready", 64'(instr_ready_po), 64'(0));
    end
    chk("halt_drained", 64'(ex_valid_po), 64'(0));
    cycle(1, 1, 16'h1298, 1, 0, 0, 0);
    chk("halt_cleared", 64'({halted_po, ex_valid_po}), 64'(0));
    cycle(0, 1, 16'h1298, 1, 0, 0, 0);
    chk("add_after_reset", 64'({arith_2op_po, rd_addr_po, rs1_addr_po, rs2_addr_po}), 64'({1'b1, 3'd1, 3'd2, 3'd3}));

    // Randomized traffic against the model
    for (int n = 0; n < 2000; n++) begin
      logic [15:0] ins;
      int unsigned r;
      r   = $urandom_range(0, 39);
      ins = 16'($urandom);
      if (r == 0) ins = 16'hFAAA;
      else if (r == 1) ins = 16'hFFFF;
      else if (r < 4) ins = {4'hF, 12'($urandom_range(0, 3))};
      cycle(($urandom_range(0, 59) == 0) || (m_halted && $urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) != 0), ins, ($urandom_range(0, 9) < 7),
            ($urandom_range(0, 2) == 0), 1'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_issue_stage.md
# decode_issue_stage

Registered decode-and-issue stage directly upstream of the 16-bit ALU. Accepts one 16-bit instruction per cycle over a valid/ready handshake and decodes it into the ALU's one-hot operation class, function code and 6-bit immediate, plus register addresses and memory/branch controls. It holds the result in a single pipeline register toward execute. It also owns the architectural carry and borrow flags that feed the ALU's carry/borrow inputs, and the HALT and software-RESET control sequencing.

## Interface
- No parameters; data width fixed at 16, register address width fixed at 3.
- clk_pi  in  1  clock; all state changes on rising edge
- reset_pi  in  1  synchronous, active-high reset
- instr_pi  in  16  instruction word
- instr_valid_pi  in  1  instr_pi is valid this cycle
- instr_ready_po  out  1  stage accepts instr_pi this cycle (combinational)
- ex_ready_pi  in  1  execute stage consumes the output register this cycle
- ex_valid_po  out  1  output register holds a decoded instruction
- arith_1op_po, arith_2op_po, addi_po, subi_po, load_or_store_po  out  1 each  one-hot ALU operation class (all 0 for non-ALU ops)
- alu_func_po  out  3  instr[2:0] for ARITH_1OP/ARITH_2OP, else 0
- immediate_po  out  6  instr[5:0] for MOVI/ADDI/SUBI/LOAD/STOR/branches, else 0
- rd_addr_po, rs1_addr_po, rs2_addr_po  out  3 each  instr[11:9], instr[8:6], instr[5:3]
- reg_write_po  out  1  destination register is written (ARITH_*, MOVI, ADDI, SUBI, LOAD)
- mem_read_po / mem_write_po  out  1  LOAD / STOR
- branch_po  out  2  00 none, 01 BEQ, 10 BGE, 11 BLE; BC reported as branch_carry_po
- branch_carry_po, jump_po  out  1  BC, J
- jump_target_po  out  12  instr[11:0] when J, else 0
- stc_cmd_po, stb_cmd_po  out  1  CONTROL code 0x001 / 0x002
- flag_we_pi  in  1  execute stage commits ALU flag outputs this cycle
- alu_carry_pi, alu_borrow_pi  in  1  ALU carry_out / borrow_out to commit
- carry_flag_po, borrow_flag_po  out  1  architectural flags, drive ALU carry/borrow inputs
- soft_reset_po  out  1  one-cycle pulse after software RESET accepted
- halted_po  out  1  stage is in HALTED

## Operation
- Opcode instr[15:12]: 0 NOP, 1 ARITH_2OP, 2 ARITH_1OP, 3 MOVI, 4 ADDI, 5 SUBI, 6 LOAD, 7 STOR, 8 BEQ, 9 BGE, A BLE, B BC, C J, F CONTROL. Opcodes D, E decode as NOP (all controls 0, still issued with ex_valid_po=1).
- CONTROL instr[11:0]: 0x001 STC, 0x002 STB, 0xAAA RESET, 0xFFF HALT; any other code decodes as NOP.
- States: RUN, HALTED. Reset enters RUN.
- Accept = instr_valid_pi & instr_ready_po. instr_ready_po = RUN & (~ex_valid_po | ex_ready_pi).
- On accept: output register loads decoded fields, ex_valid_po<=1. Else if ex_ready_pi: ex_valid_po<=0 (fields hold their value).
- HALT accepted: issued as NOP (all controls 0), state -> HALTED; instr_ready_po=0 thereafter. Only reset_pi leaves HALTED. Output register continues draining under ex_ready_pi.
- RESET accepted: nothing issued (ex_valid_po<=0); next cycle soft_reset_po=1, carry/borrow flags <=0. Stage stays in RUN.
- Flags: when flag_we_pi, carry_flag_po<=alu_carry_pi, borrow_flag_po<=alu_borrow_pi. A RESET accept in the same cycle wins (flags cleared).
- Immediate passes unmodified as 6-bit zero-extended value; sign handling belongs downstream.

## Timing
- Reset values: ex_valid_po=0, all decoded outputs 0, carry_flag_po=0, borrow_flag_po=0, soft_reset_po=0, halted_po=0, state RUN.
- Latency: instruction accepted at edge N is on outputs after edge N (1 cycle); throughput 1/cycle with ex_ready_pi held high.
- Back-pressure: ex_valid_po=1 & ex_ready_pi=0 holds output register stable and instr_ready_po=0.
- Flag update visible one cycle after flag_we_pi.
- halted_po rises the cycle after the HALT accept edge.
- reset_pi mid-operation: discards the in-flight output register and flags regardless of handshake.

## Test plan
- ADD r1=r2+r3: instr 0x1298, valid, ex_ready=1 -> next cycle ex_valid=1, arith_2op=1, func=0, rd=1, rs1=2, rs2=3, reg_write=1, others 0.
- ADDI 0x4285 then stall ex_ready=0 for 3 cycles with 0x5285 offered -> addi=1, imm=5 held stable, instr_ready=0; on release SUBI issued next cycle.
- flag_we=1, alu_carry=1, alu_borrow=0 -> carry_flag=1, borrow_flag=0 next cycle; then 0xFAAA accepted with flag_we=1 -> soft_reset pulse one cycle, both flags 0, nothing issued.
- STC 0xF001 -> stc_cmd=1, all ALU class bits 0; 0xF123 -> all controls 0, ex_valid=1.
- HALT 0xFFFF then 0x1298 valid -> NOP issued, halted_po=1, instr_ready=0 forever; reset_pi 1 cycle -> RUN, ADD accepted next.
- J 0xC07B -> jump=1, jump_target=0x07B, reg_write=0; BEQ 0x8285 -> branch=01, imm=5.
